// File: rtl/accumulator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_ctrl
// Purpose  : Run/pause/done sequencer for the accumulator datapath. It drives
//            a prescaled write-enable tick and clear pulses, and watches the
//            accumulator output for the terminal count.
// Options  : define ACC_CTRL_WRAP_EN to wrap LIMIT->0 instead of stopping.
// Revision : 1.0 - initial release
// ============================================================================
module accumulator_ctrl #(
    parameter int unsigned DIV   = 50_000_000,
    parameter logic [7:0]  LIMIT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       clear_btn,
    input  logic [7:0] acc_value,
    output logic       acc_w_en,
    output logic       acc_clr,
    output logic       busy,
    output logic       done
);

    localparam int unsigned    PW      = $clog2(DIV);
    localparam logic [PW-1:0]  PRE_MAX = PW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          start_q, stop_q, clear_q;
    logic          init_q;
    logic          acc_w_en_q, acc_w_en_d;
    logic          acc_clr_q, acc_clr_d;
    logic          busy_q, done_q;

    logic w_start_rise, w_stop_rise, w_clear_rise;
    logic w_tick, w_at_limit, w_terminal;

    assign w_start_rise = start_btn & ~start_q;
    assign w_stop_rise  = stop_btn  & ~stop_q;
    assign w_clear_rise = clear_btn & ~clear_q;

    assign w_tick     = (state_q == S_RUN) && (pre_q == PRE_MAX);
    assign w_at_limit = (acc_value == LIMIT);
    // A tick is only honoured when neither clear nor stop claims the cycle.
    assign w_terminal = w_tick && w_at_limit && !w_clear_rise && !w_stop_rise;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!w_clear_rise && !w_stop_rise && w_start_rise) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_clear_rise) begin
                    state_d = S_IDLE;
                end else if (w_stop_rise) begin
                    state_d = S_PAUSE;
                end else if (w_terminal) begin
`ifdef ACC_CTRL_WRAP_EN
                    state_d = S_RUN;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_PAUSE: begin
                if (w_clear_rise) begin
                    state_d = S_IDLE;
                end else if (!w_stop_rise && w_start_rise) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (w_clear_rise) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        acc_w_en_d = w_tick && !w_at_limit && !w_clear_rise && !w_stop_rise;
        acc_clr_d  = init_q || w_clear_rise;
`ifdef ACC_CTRL_WRAP_EN
        acc_clr_d  = acc_clr_d || w_terminal;
`endif

        pre_d = '0;
        if ((state_d == S_RUN) || (state_d == S_PAUSE)) begin
            if (state_q == S_RUN) begin
                pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
            end else begin
                pre_d = pre_q;
            end
        end
    end

    // Edge registers reset high so a button held through reset never fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q      <= '0;
            start_q    <= 1'b1;
            stop_q     <= 1'b1;
            clear_q    <= 1'b1;
            init_q     <= 1'b1;
            acc_w_en_q <= 1'b0;
            acc_clr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            start_q    <= start_btn;
            stop_q     <= stop_btn;
            clear_q    <= clear_btn;
            init_q     <= 1'b0;
            acc_w_en_q <= acc_w_en_d;
            acc_clr_q  <= acc_clr_d;
            busy_q     <= (state_d == S_RUN);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign acc_w_en = acc_w_en_q;
    assign acc_clr  = acc_clr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_accumulator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulator_ctrl
// Purpose  : Self-checking bench for accumulator_ctrl with DIV=4, LIMIT=5 and a
//            behavioural accumulator (clr->0, w_en->+1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulator_ctrl;

    localparam int         DIV   = 4;
    localparam logic [7:0] LIMIT = 8'd5;

    logic       clk = 1'b0;
    logic       reset, start_btn, stop_btn, clear_btn;
    logic       acc_w_en, acc_clr, busy, done;
    logic [7:0] acc_q = 8'd0;

    int n_checks = 0;
    int n_errors = 0;

    accumulator_ctrl #(.DIV(DIV), .LIMIT(LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .clear_btn (clear_btn),
        .acc_value (acc_q),
        .acc_w_en  (acc_w_en),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (acc_clr)       acc_q <= 8'd0;
        else if (acc_w_en) acc_q <= acc_q + 8'd1;
    end

    // ---------------- reference model ----------------
    bit         m_prev_s = 1, m_prev_p = 1, m_prev_c = 1, m_init = 1;
    bit         m_running = 0, m_paused = 0, m_finished = 0;
    int         m_phase = 0;
    bit         m_wen = 0, m_clr = 0;
    logic [7:0] m_acc = 8'd0;

    task automatic model_predict(input bit r, input bit s, input bit p, input bit c);
        bit rs, rp, rc, tick, nw, nc;
        logic [7:0] acc_n;
        acc_n = m_clr ? 8'd0 : (m_wen ? m_acc + 8'd1 : m_acc);
        nw = 0;
        nc = 0;
        if (r) begin
            m_prev_s = 1; m_prev_p = 1; m_prev_c = 1; m_init = 1;
            m_running = 0; m_paused = 0; m_finished = 0; m_phase = 0;
        end else begin
            rs = s && !m_prev_s;
            rp = p && !m_prev_p;
            rc = c && !m_prev_c;
            nc = m_init;
            m_init = 0;
            if (rc) begin
                nc = 1;
                m_running = 0; m_paused = 0; m_finished = 0; m_phase = 0;
            end else if (m_running) begin
                tick = (m_phase == DIV - 1);
                m_phase = (m_phase + 1) % DIV;
                if (rp) begin
                    m_running = 0;
                    m_paused  = 1;
                end else if (tick) begin
                    if (m_acc != LIMIT) nw = 1;
                    else begin
`ifdef ACC_CTRL_WRAP_EN
                        nc = 1;
`else
                        m_running = 0; m_finished = 1; m_phase = 0;
`endif
                    end
                end
            end else if (m_paused) begin
                if (rs && !rp) begin
                    m_paused  = 0;
                    m_running = 1;
                end
            end else if (!m_finished && rs && !rp) begin
                m_running = 1;
                m_phase   = 0;
            end
            m_prev_s = s; m_prev_p = p; m_prev_c = c;
        end
        m_wen = nw;
        m_clr = nc;
        m_acc = acc_n;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs and compare the DUT with the model afterwards.
    task automatic step(input bit r, input bit s, input bit p, input bit c);
        reset = r; start_btn = s; stop_btn = p; clear_btn = c;
        model_predict(r, s, p, c);
        @(posedge clk);
        #1;
        check("model_w_en", int'(acc_w_en), int'(m_wen));
        check("model_clr",  int'(acc_clr),  int'(m_clr));
        check("model_busy", int'(busy),     int'(m_busy()));
        check("model_done", int'(done),     int'(m_finished));
        check("model_acc",  int'(acc_q),    int'(m_acc));
    endtask

    function automatic bit m_busy();
        return m_running;
    endfunction

    task automatic wait_wen(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(0, 0, 0, 0);
            seen = acc_w_en;
        end
        check({name, "_wen_timeout"}, int'(seen), 1);
    endtask

    typedef struct {
        bit r, s, p, c;
        bit w, k, b, d;
        logic [7:0] acc;
    } vec_t;

    vec_t vecs[15];

    initial begin
        automatic int cnt;
        automatic bit seen;
        // reset with start held, then a start edge and two ticks
        vecs[0]  = '{1,1,0,0, 0,0,0,0, 8'd0};
        vecs[1]  = '{1,1,0,0, 0,0,0,0, 8'd0};
        vecs[2]  = '{1,1,0,0, 0,0,0,0, 8'd0};
        vecs[3]  = '{0,1,0,0, 0,1,0,0, 8'd0};
        vecs[4]  = '{0,1,0,0, 0,0,0,0, 8'd0};
        vecs[5]  = '{0,0,0,0, 0,0,0,0, 8'd0};
        vecs[6]  = '{0,1,0,0, 0,0,1,0, 8'd0};
        vecs[7]  = '{0,1,0,0, 0,0,1,0, 8'd0};
        vecs[8]  = '{0,0,0,0, 0,0,1,0, 8'd0};
        vecs[9]  = '{0,0,0,0, 0,0,1,0, 8'd0};
        vecs[10] = '{0,0,0,0, 1,0,1,0, 8'd0};
        vecs[11] = '{0,0,0,0, 0,0,1,0, 8'd1};
        vecs[12] = '{0,0,0,0, 0,0,1,0, 8'd1};
        vecs[13] = '{0,0,0,0, 0,0,1,0, 8'd1};
        vecs[14] = '{0,0,0,0, 1,0,1,0, 8'd1};

        reset = 1; start_btn = 1; stop_btn = 0; clear_btn = 0;
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].c);
            check($sformatf("vec%0d_w_en", i), int'(acc_w_en), int'(vecs[i].w));
            check($sformatf("vec%0d_clr",  i), int'(acc_clr),  int'(vecs[i].k));
            check($sformatf("vec%0d_busy", i), int'(busy),     int'(vecs[i].b));
            check($sformatf("vec%0d_done", i), int'(done),     int'(vecs[i].d));
            check($sformatf("vec%0d_acc",  i), int'(acc_q),    int'(vecs[i].acc));
        end

        // stop at pre=2, resume 10 cycles later
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("pause_busy", int'(busy), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            cnt += int'(acc_w_en);
        end
        check("pause_no_wen", cnt, 0);
        step(0, 1, 0, 0);
        check("resume_busy", int'(busy), 1);
        check("resume_wen0", int'(acc_w_en), 0);
        step(0, 0, 0, 0);
        check("resume_wen1", int'(acc_w_en), 1);
        step(0, 0, 0, 0);
        check("resume_acc", int'(acc_q), 3);

`ifdef ACC_CTRL_WRAP_EN
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(0, 0, 0, 0);
            seen = acc_clr && busy;
        end
        check("wrap_clr_seen", int'(seen), 1);
        check("wrap_done", int'(done), 0);
        step(0, 0, 0, 0);
        check("wrap_acc0", int'(acc_q), 0);
        wait_wen("wrap");
        step(0, 0, 0, 0);
        check("wrap_acc1", int'(acc_q), 1);
        check("wrap_done2", int'(done), 0);
`else
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            step(0, 0, 0, 0);
            seen = done;
        end
        check("done_seen", int'(seen), 1);
        check("done_acc", int'(acc_q), 5);
        check("done_busy", int'(busy), 0);
        step(0, 1, 0, 0);
        check("done_start_ign", int'(done), 1);
        check("done_no_wen", int'(acc_w_en), 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("done_stop_ign", int'(done), 1);
        check("done_acc_frozen", int'(acc_q), 5);
`endif
        step(0, 0, 0, 1);
        check("clear_pulse", int'(acc_clr), 1);
        check("clear_done", int'(done), 0);
        step(0, 0, 0, 0);
        check("clear_acc", int'(acc_q), 0);
        check("clear_busy", int'(busy), 0);

        // clear and stop rise together on a tick cycle
        step(0, 1, 0, 0);
        wait_wen("t6");
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        check("tickclr_wen", int'(acc_w_en), 0);
        check("tickclr_clr", int'(acc_clr), 1);
        check("tickclr_busy", int'(busy), 0);
        step(0, 0, 0, 0);
        check("tickclr_wen2", int'(acc_w_en), 0);

        // reset in the middle of a run
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_wen", int'(acc_w_en), 0);
        step(0, 0, 0, 0);
        check("midrst_clr", int'(acc_clr), 1);
        step(0, 0, 0, 0);
        check("midrst_clr_end", int'(acc_clr), 0);

        // random button traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 200) == 0, ($urandom % 4) == 0,
                 ($urandom % 20) == 0, ($urandom % 40) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors",
                 n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
